// File: rtl/sd_page_arbiter.sv
// sd_page_arbiter
//   Arbitrates two byte-read requesters (port 0 = instruction fetch,
//   port 1 = data load) onto the single byte-wide SD page-cache port.
//   The winner's address is latched and presented with sd_enable until the
//   pager reports not-busy. The returned byte is captured and the requester
//   gets a one-cycle ack. A watchdog turns a stuck refill into a one-cycle
//   err pulse instead of hanging the CPU.
//
//   Optional build macro: SD_ARB_ROUND_ROBIN_EN
//     defined   : on simultaneous requests the port not equal to grant wins
//     undefined : fixed priority, port 0 wins
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     req0/addr0            port 0 level request and byte address
//     ack0/rdata0/err0      port 0 done pulse, read data, timeout pulse
//     req1/addr1/ack1/rdata1/err1   same for port 1
//     sd_address/sd_enable  address and refill enable to the pager
//     sd_data_in/sd_busy    pager data and busy
//     grant                 port currently or last served
module sd_page_arbiter #(
  parameter int ADDR_WIDTH    = 24,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  ack0,
  output logic [7:0]            rdata0,
  output logic                  err0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  ack1,
  output logic [7:0]            rdata1,
  output logic                  err1,
  output logic [ADDR_WIDTH-1:0] sd_address,
  output logic                  sd_enable,
  input  logic [7:0]            sd_data_in,
  input  logic                  sd_busy,
  output logic                  grant
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_BITS-1:0] WD_ONE  = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
  // Last busy cycle allowed: the increment taken here reaches all-ones.
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, DONE} state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic                    enable_r, enable_s;
  logic                    grant_r, grant_s;
  logic                    ack0_r, ack0_s, ack1_r, ack1_s;
  logic                    err0_r, err0_s, err1_r, err1_s;
  logic [7:0]              rdata0_r, rdata0_s, rdata1_r, rdata1_s;
  logic [SW-1:0]           settle_r, settle_s;
  logic [TIMEOUT_BITS-1:0] wdog_r, wdog_s;
  logic                    pick_s;

  // Arbitration: which port wins if a request is seen in IDLE.
  always_comb begin
    pick_s = 1'b0;
`ifdef SD_ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      pick_s = ~grant_r;
    end else if (req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
`else
    if (req0) begin
      pick_s = 1'b0;
    end else begin
      pick_s = 1'b1;
    end
`endif
  end

  // Next-state and next-output logic for the service FSM.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    enable_s = enable_r;
    grant_s  = grant_r;
    ack0_s   = 1'b0;
    ack1_s   = 1'b0;
    err0_s   = 1'b0;
    err1_s   = 1'b0;
    rdata0_s = rdata0_r;
    rdata1_s = rdata1_r;
    settle_s = settle_r;
    wdog_s   = wdog_r;
    case (state_r)
      IDLE: begin
        wdog_s = {TIMEOUT_BITS{1'b0}};
        if (req0 || req1) begin
          grant_s  = pick_s;
          addr_s   = pick_s ? addr1 : addr0;
          enable_s = 1'b1;
          settle_s = SETTLE_LOAD;
          state_s  = SETTLE;
        end else begin
          enable_s = 1'b0;
          state_s  = IDLE;
        end
      end
      SETTLE: begin
        // Address held long enough for the pager to decide hit or miss.
        enable_s = 1'b1;
        if (settle_r == {SW{1'b0}}) begin
          state_s = WAIT;
        end else begin
          settle_s = settle_r - SETTLE_ONE;
        end
      end
      WAIT: begin
        if (!sd_busy) begin
          enable_s = 1'b0;
          state_s  = DONE;
          if (grant_r) begin
            rdata1_s = sd_data_in;
            ack1_s   = 1'b1;
          end else begin
            rdata0_s = sd_data_in;
            ack0_s   = 1'b1;
          end
        end else if (wdog_r == WD_LAST) begin
          // Card not responding: give up, leave rdata untouched.
          wdog_s   = wdog_r + WD_ONE;
          enable_s = 1'b0;
          state_s  = DONE;
          if (grant_r) begin
            err1_s = 1'b1;
          end else begin
            err0_s = 1'b1;
          end
        end else begin
          wdog_s   = wdog_r + WD_ONE;
          enable_s = 1'b1;
        end
      end
      DONE: begin
        // One quiet cycle lets the requester drop or renew its request.
        wdog_s   = {TIMEOUT_BITS{1'b0}};
        enable_s = 1'b0;
        state_s  = IDLE;
      end
      default: begin
        enable_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      enable_r <= 1'b0;
      grant_r  <= 1'b1;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
      rdata0_r <= 8'h00;
      rdata1_r <= 8'h00;
      settle_r <= {SW{1'b0}};
      wdog_r   <= {TIMEOUT_BITS{1'b0}};
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      enable_r <= enable_s;
      grant_r  <= grant_s;
      ack0_r   <= ack0_s;
      ack1_r   <= ack1_s;
      err0_r   <= err0_s;
      err1_r   <= err1_s;
      rdata0_r <= rdata0_s;
      rdata1_r <= rdata1_s;
      settle_r <= settle_s;
      wdog_r   <= wdog_s;
    end
  end

  assign sd_address = addr_r;
  assign sd_enable  = enable_r;
  assign grant      = grant_r;
  assign ack0       = ack0_r;
  assign ack1       = ack1_r;
  assign err0       = err0_r;
  assign err1       = err1_r;
  assign rdata0     = rdata0_r;
  assign rdata1     = rdata1_r;

endmodule

// File: tb/tb_sd_page_arbiter.sv
// Testbench for sd_page_arbiter: a cycle-stepped page-cache model answers the
// arbiter, and a transaction-level reference predicts service order and the
// cycle of every ack/err pulse from the arbitration and latency rules.
module tb_sd_page_arbiter;
  localparam int AW      = 24;
  localparam int SETTLE  = 2;
  localparam int TO_BITS = 10;
  localparam int WD_MAX  = (1 << TO_BITS) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          ack0, ack1, err0, err1;
  logic [7:0]    rdata0, rdata1;
  logic [AW-1:0] sd_address;
  logic          sd_enable;
  logic [7:0]    sd_data_in;
  logic          sd_busy;
  logic          grant;

  sd_page_arbiter #(.ADDR_WIDTH(AW), .SETTLE_CYCLES(SETTLE), .TIMEOUT_BITS(TO_BITS)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .addr1(addr1), .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .sd_address(sd_address), .sd_enable(sd_enable),
    .sd_data_in(sd_data_in), .sd_busy(sd_busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pager model contents: per-address miss length and data.
  logic [AW-1:0] pg_a0, pg_a1;
  int            pg_m0, pg_m1;
  logic [7:0]    pg_d0, pg_d1;
  int            en_run = 0;

  // Reference model state.
  logic          m_grant;
  logic [7:0]    m_rd[2];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and update the pager's response for the new cycle.
  task automatic step();
    int m;
    @(posedge clk);
    #1;
    if (sd_enable) en_run++;
    else en_run = 0;
    if (sd_address == pg_a0) begin
      m = pg_m0; sd_data_in = pg_d0;
    end else if (sd_address == pg_a1) begin
      m = pg_m1; sd_data_in = pg_d1;
    end else begin
      m = 0; sd_data_in = sd_address[7:0] ^ 8'hC3;
    end
    sd_busy = sd_enable && (en_run <= SETTLE + m);
  endtask

  task automatic model_reset();
    m_grant = 1'b1;
    m_rd[0] = 8'h00;
    m_rd[1] = 8'h00;
  endtask

  // One round: the selected ports request together; runs until the last
  // predicted ack/err and checks every cycle on the way.
  task automatic run_round(input bit r0, input bit r1, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input int m0, input int m1, input logic [7:0] d0, input logic [7:0] d1,
                           input bit early_drop, input bit move_addr);
    int port_q[2];
    int ev_c[2];
    bit ev_err[2];
    int mm[2];
    logic [AW-1:0] oa[2];
    int nserv, idle_c, st, p, last;
    logic [4:0] exp_ctl;
    mm[0] = m0; mm[1] = m1; oa[0] = a0; oa[1] = a1;
    pg_a0 = a0; pg_a1 = a1; pg_m0 = m0; pg_m1 = m1; pg_d0 = d0; pg_d1 = d1;
    if (r0 && r1) begin
`ifdef SD_ARB_ROUND_ROBIN_EN
      port_q[0] = (m_grant == 1'b0) ? 1 : 0;
`else
      port_q[0] = 0;
`endif
      port_q[1] = 1 - port_q[0];
      nserv = 2;
    end else begin
      port_q[0] = r0 ? 0 : 1;
      port_q[1] = 0;
      nserv = 1;
    end
    idle_c = 0;
    for (int i = 0; i < nserv; i++) begin
      ev_err[i] = (mm[port_q[i]] >= WD_MAX);
      ev_c[i]   = ev_err[i] ? idle_c + 3 + WD_MAX : idle_c + 4 + mm[port_q[i]];
      idle_c    = ev_c[i] + 1;
    end
    last = ev_c[nserv-1];
    step();
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    for (int t = 0; t <= last; t++) begin
      if (t > 0) step();
      exp_ctl = 5'b00000;
      for (int i = 0; i < nserv; i++) begin
        st = (i == 0) ? 0 : ev_c[i-1] + 1;
        if (t > st && t < ev_c[i]) exp_ctl[0] = 1'b1;
        if (t == ev_c[i]) begin
          if (port_q[i] == 0) exp_ctl[ev_err[i] ? 2 : 4] = 1'b1;
          else                exp_ctl[ev_err[i] ? 1 : 3] = 1'b1;
        end
      end
      check_value("ctl{ack0,ack1,err0,err1,en}", 32'({ack0, ack1, err0, err1, sd_enable}), 32'(exp_ctl));
      for (int i = 0; i < nserv; i++) begin
        p = port_q[i];
        if (t == ev_c[i] - 1) check_value("sd_address", 32'(sd_address), 32'(oa[p]));
        if (t == ev_c[i]) begin
          if (!ev_err[i]) m_rd[p] = (p == 0) ? d0 : d1;
          m_grant = p[0];
          check_value("grant", 32'(grant), 32'(m_grant));
          check_value("rdata0", 32'(rdata0), 32'(m_rd[0]));
          check_value("rdata1", 32'(rdata1), 32'(m_rd[1]));
          if (p == 0) req0 = 1'b0;
          else        req1 = 1'b0;
        end
      end
      if (t == 1 && early_drop) begin
        if (port_q[0] == 0) req0 = 1'b0;
        else                req1 = 1'b0;
      end
      if (t == 1 && move_addr) begin
        if (port_q[0] == 0) addr0 = ~a0;
        else                addr1 = ~a1;
      end
    end
  endtask

  initial begin
    logic [AW-1:0] ra0, ra1;
    bit rr0, rr1;
    int rm0, rm1, gap;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    sd_busy = 1'b0; sd_data_in = 8'h00;
    pg_a0 = 24'hFFFFFE; pg_a1 = 24'hFFFFFD; pg_m0 = 0; pg_m1 = 0; pg_d0 = 8'h00; pg_d1 = 8'h00;
    model_reset();
    repeat (3) step();
    check_value("rst_ctl", 32'({ack0, ack1, err0, err1, sd_enable}), 32'(5'b00000));
    check_value("rst_addr", 32'(sd_address), 32'(0));
    check_value("rst_grant", 32'(grant), 32'(1));
    check_value("rst_rdata", 32'({rdata0, rdata1}), 32'(0));
    reset = 1'b0;

    // Single hit, miss with long refill, contention (twice).
    run_round(1'b1, 1'b0, 24'h001234, 24'hFFFFFF, 0, 0, 8'hA5, 8'h00, 1'b0, 1'b0);
    run_round(1'b0, 1'b1, 24'hFFFFFF, 24'h00F000, 0, 600, 8'h00, 8'h3C, 1'b0, 1'b0);
    run_round(1'b1, 1'b1, 24'h000100, 24'h000200, 0, 0, 8'h11, 8'h22, 1'b0, 1'b0);
    run_round(1'b1, 1'b1, 24'h000300, 24'h000400, 0, 0, 8'h33, 8'h44, 1'b0, 1'b0);
    // Watchdog boundary: one cycle short of timeout acks, full length errs.
    run_round(1'b1, 1'b0, 24'h010000, 24'hFFFFFF, WD_MAX - 1, 0, 8'h5D, 8'h00, 1'b0, 1'b0);
    run_round(1'b1, 1'b0, 24'h020000, 24'hFFFFFF, WD_MAX, 0, 8'hE7, 8'h00, 1'b0, 1'b0);
    run_round(1'b0, 1'b1, 24'hFFFFFF, 24'h030000, 0, 0, 8'h00, 8'h96, 1'b0, 1'b0);
    // Address moved during service, request dropped early.
    run_round(1'b1, 1'b0, 24'h0ABC00, 24'hFFFFFF, 3, 0, 8'h4B, 8'h00, 1'b0, 1'b1);
    run_round(1'b1, 1'b0, 24'h0DEF00, 24'hFFFFFF, 0, 0, 8'h69, 8'h00, 1'b1, 1'b0);

    // Reset during a refill wait.
    step();
    pg_a0 = 24'h00ABCD; pg_m0 = 100; pg_d0 = 8'h77;
    addr0 = 24'h00ABCD; req0 = 1'b1;
    for (int t = 1; t <= 10; t++) step();
    check_value("pre_rst_en", 32'(sd_enable), 32'(1));
    reset = 1'b1; req0 = 1'b0;
    step();
    model_reset();
    check_value("midrst_ctl", 32'({ack0, ack1, err0, err1, sd_enable}), 32'(5'b00000));
    check_value("midrst_grant", 32'(grant), 32'(1));
    check_value("midrst_rdata0", 32'(rdata0), 32'(0));
    reset = 1'b0;
    run_round(1'b1, 1'b0, 24'h00ABCD, 24'hFFFFFF, 100, 0, 8'h77, 8'h00, 1'b0, 1'b0);

    // Randomized rounds.
    for (int n = 0; n < 40; n++) begin
      ra0 = AW'($urandom());
      ra1 = AW'($urandom());
      if (ra1 == ra0) ra1 = ra0 ^ 24'h000001;
      rr0 = $urandom_range(0, 1) == 1;
      rr1 = $urandom_range(0, 1) == 1;
      if (!rr0 && !rr1) rr0 = 1'b1;
      rm0 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      rm1 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      run_round(rr0, rr1, ra0, ra1, rm0, rm1, 8'($urandom()), 8'($urandom()),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        check_value("gap_ctl", 32'({ack0, ack1, err0, err1, sd_enable}), 32'(5'b00000));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
